// File: rtl/hex_score_ctrl.sv
// hex_score_ctrl: binary score/timer value to BCD digits and 7-segment HEX drive.
// Serial shift-add-3 conversion (one bit per clock), saturation to 10^NDIG-1,
// leading-zero blanking and one hex_decoder per digit.
// Optional display blinking is compiled in when the macro HEX_BLINK_EN is defined.

// Active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
module hex_decoder (
  input  logic [3:0] bin_i,
  output logic [6:0] seg_o
);

  // Map one nibble to its active-low segment pattern.
  always_comb begin
    case (bin_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      4'hF:    seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

module hex_score_ctrl #(
  parameter int WIDTH     = 14,
  parameter int NDIG      = 4,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    value_in,
  input  logic                load,
  input  logic                blink,
  output logic                ready,
  output logic                done,
  output logic                ovf,
  output logic [4*NDIG-1:0]   digits,
  output logic [7*NDIG-1:0]   hex
);

  localparam int          BW        = 4 * NDIG;
  localparam int          CW        = $clog2(WIDTH + 1);
  localparam logic [63:0] MAXV      = 64'(10 ** NDIG - 1);
  // Reset display: digit 0 shows "0", every higher digit blank.
  localparam logic [NDIG-1:0] BLANK_RST = ~(NDIG'(1'b1));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  state_e          state_q;
  logic            ready_q;
  logic            done_q;
  logic            ovf_q;
  logic [BW-1:0]   digits_q;
  logic [NDIG-1:0] blank_q;
  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0]   bcd_q;
  logic [CW-1:0]   cnt_q;

  logic [63:0]      value_ext_s;
  logic             sat_s;
  logic [WIDTH-1:0] sat_val_s;
  logic [BW-1:0]    bcd_adj_s;
  logic [BW-1:0]    bcd_shift_d;
  logic [NDIG-1:0]  blank_d;
  logic             nz_s;
  logic             phase_s;
  logic             unused_s;

  assign value_ext_s = 64'(value_in);

  // Clamp out-of-range inputs to the largest displayable value.
  always_comb begin
    if (value_ext_s > MAXV) begin
      sat_s     = 1'b1;
      sat_val_s = MAXV[WIDTH-1:0];
    end else begin
      sat_s     = 1'b0;
      sat_val_s = value_in;
    end
  end

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  always_comb begin
    bcd_adj_s = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // The corrected accumulator takes the next binary MSB; the top bit drops off.
  assign bcd_shift_d = {bcd_adj_s[BW-2:0], bin_q[WIDTH-1]};

  // Leading-zero mask: digit i blank when it and all higher digits are zero.
  always_comb begin
    nz_s    = 1'b0;
    blank_d = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      nz_s       = nz_s | (bcd_q[4*i +: 4] != 4'd0);
      blank_d[i] = ~nz_s;
    end
  end

  // Conversion FSM with registered handshake and display outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
      blank_q  <= BLANK_RST;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            bin_q   <= sat_val_s;
            ovf_q   <= sat_s;
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            ready_q <= 1'b0;
            state_q <= ST_SHIFT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_shift_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_UPDATE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_UPDATE: begin
          digits_q <= bcd_q;
          blank_q  <= blank_d;
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef HEX_BLINK_EN
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCW-1:0] blink_cnt_q;
  logic           phase_q;

  // Blink timebase: toggle phase every BLINK_DIV cycles while blink is held.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (!blink) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BCW'(1);
    end
  end

  assign phase_s  = phase_q;
  assign unused_s = bcd_adj_s[BW-1];
`else
  assign phase_s  = 1'b0;
  assign unused_s = ^{bcd_adj_s[BW-1], blink, (BLINK_DIV != 0)};
`endif

  // One decoder per digit; blanked or blink-off digits show nothing.
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    logic [6:0] seg_s;
    hex_decoder u_dec (
      .bin_i (digits_q[4*g +: 4]),
      .seg_o (seg_s)
    );
    assign hex[7*g +: 7] = (blank_q[g] | phase_s) ? 7'h7F : seg_s;
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digits = digits_q;

endmodule

// File: tb/tb_hex_score_ctrl.sv
// Self-checking bench for hex_score_ctrl (WIDTH=14, NDIG=4, BLINK_DIV=4).
module tb_hex_score_ctrl;

  localparam logic [6:0] B   = 7'h7F;
  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0010000;

  typedef struct {
    logic [13:0] val;
    logic [15:0] dig;
    logic        ovf;
    logic [27:0] hx;
  } vec_t;

  logic        clock;
  logic        resetn;
  logic [13:0] value_in;
  logic        load;
  logic        blink;
  logic        ready;
  logic        done;
  logic        ovf;
  logic [15:0] digits;
  logic [27:0] hex;

  int          tests_run;
  int          tests_failed;
  vec_t        sb[$];
  vec_t        tbl[10];
  logic [15:0] last_dig;
  logic [27:0] hex_rst;

  hex_score_ctrl #(
    .WIDTH     (14),
    .NDIG      (4),
    .BLINK_DIV (4)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .value_in (value_in),
    .load     (load),
    .blink    (blink),
    .ready    (ready),
    .done     (done),
    .ovf      (ovf),
    .digits   (digits),
    .hex      (hex)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for done, starting at a negedge where the last edge was E_n0.
  task automatic wait_and_check(input int n0);
    int   n;
    int   busy_bad;
    int   hold_bad;
    vec_t e;
    n = n0;
    busy_bad = 0;
    hold_bad = 0;
    while (done !== 1'b1 && n < 40) begin
      if (ready !== 1'b0) busy_bad++;
      if (digits !== last_dig) hold_bad++;
      @(negedge clock);
      n++;
    end
    chk("latency", 64'(n), 64'(15));
    chk("ready_low_while_busy", 64'(busy_bad), 64'(0));
    chk("digits_held", 64'(hold_bad), 64'(0));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      chk($sformatf("digits_%0d", e.val), 64'(digits), 64'(e.dig));
      chk($sformatf("ovf_%0d", e.val), 64'(ovf), 64'(e.ovf));
      chk($sformatf("hex_%0d", e.val), 64'(hex), 64'(e.hx));
      chk($sformatf("ready_at_done_%0d", e.val), 64'(ready), 64'(1));
      last_dig = e.dig;
    end
  endtask

  task automatic run_conv(input vec_t v);
    @(negedge clock);
    value_in = v.val;
    load     = 1'b1;
    sb.push_back(v);
    @(negedge clock);
    load = 1'b0;
    wait_and_check(0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},  64'(ready),  64'(1));
    chk({tag, "_done"},   64'(done),   64'(0));
    chk({tag, "_ovf"},    64'(ovf),    64'(0));
    chk({tag, "_digits"}, 64'(digits), 64'(0));
    chk({tag, "_hex"},    64'(hex),    64'(hex_rst));
  endtask

  initial begin
    vec_t v42;
    vec_t v300;
    vec_t v1234;
    int   n;
    int   bad;
    tests_run    = 0;
    tests_failed = 0;
    last_dig     = 16'h0000;
    hex_rst      = {B, B, B, S0};
    resetn       = 1'b0;
    value_in     = 14'd0;
    load         = 1'b0;
    blink        = 1'b0;

    tbl[0] = '{val: 14'd1234,  dig: 16'h1234, ovf: 1'b0, hx: {S1, S2, S3, S4}};
    tbl[1] = '{val: 14'd7,     dig: 16'h0007, ovf: 1'b0, hx: {B, B, B, S7}};
    tbl[2] = '{val: 14'd12000, dig: 16'h9999, ovf: 1'b1, hx: {S9, S9, S9, S9}};
    tbl[3] = '{val: 14'd50,    dig: 16'h0050, ovf: 1'b0, hx: {B, B, S5, S0}};
    tbl[4] = '{val: 14'd0,     dig: 16'h0000, ovf: 1'b0, hx: {B, B, B, S0}};
    tbl[5] = '{val: 14'd9999,  dig: 16'h9999, ovf: 1'b0, hx: {S9, S9, S9, S9}};
    tbl[6] = '{val: 14'd10000, dig: 16'h9999, ovf: 1'b1, hx: {S9, S9, S9, S9}};
    tbl[7] = '{val: 14'd16383, dig: 16'h9999, ovf: 1'b1, hx: {S9, S9, S9, S9}};
    tbl[8] = '{val: 14'd1005,  dig: 16'h1005, ovf: 1'b0, hx: {S1, S0, S0, S5}};
    tbl[9] = '{val: 14'd808,   dig: 16'h0808, ovf: 1'b0, hx: {B, S8, S0, S8}};
    v42   = '{val: 14'd42,   dig: 16'h0042, ovf: 1'b0, hx: {B, B, S4, S2}};
    v300  = '{val: 14'd300,  dig: 16'h0300, ovf: 1'b0, hx: {B, S3, S0, S0}};
    v1234 = tbl[0];

    // Reset and hold
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_state("reset");

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      run_conv(tbl[i]);
    end

    // load held high retriggers in the done cycle
    @(negedge clock);
    value_in = v42.val;
    load     = 1'b1;
    sb.push_back(v42);
    @(negedge clock);
    wait_and_check(0);
    value_in = v300.val;
    sb.push_back(v300);
    @(negedge clock);
    chk("retrigger_ready", 64'(ready), 64'(0));
    load = 1'b0;
    wait_and_check(0);

    // Load during conversion is ignored
    @(negedge clock);
    value_in = v1234.val;
    load     = 1'b1;
    sb.push_back(v1234);
    @(negedge clock);
    load = 1'b0;
    repeat (4) @(negedge clock);
    value_in = 14'd5678;
    load     = 1'b1;
    @(negedge clock);
    load = 1'b0;
    wait_and_check(5);
    repeat (3) @(negedge clock);
    chk("ignored_load_no_restart", 64'(ready), 64'(1));
    chk("ignored_load_digits", 64'(digits), 64'(16'h1234));

    // Reset mid-conversion of 4321
    @(negedge clock);
    value_in = 14'd4321;
    load     = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (9) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(negedge clock);
    @(negedge clock);
    resetn   = 1'b1;
    last_dig = 16'h0000;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done !== 1'b0 || ready !== 1'b1) bad++;
    end
    chk("aborted_no_done", 64'(bad), 64'(0));
    chk_reset_state("after_abort");

    // Blink behaviour with 42 displayed
    run_conv(v42);
    @(negedge clock);
    blink = 1'b1;
    bad   = 0;
    for (n = 1; n <= 16; n++) begin
      @(negedge clock);
`ifdef HEX_BLINK_EN
      if (((n / 4) % 2) == 1) begin
        if (hex !== {B, B, B, B}) bad++;
      end else begin
        if (hex !== v42.hx) bad++;
      end
`else
      if (hex !== v42.hx) bad++;
`endif
      chk("blink_digits", 64'(digits), 64'(16'h0042));
    end
    chk("blink_pattern", 64'(bad), 64'(0));
    blink = 1'b0;
    @(negedge clock);
    chk("blink_off_hex", 64'(hex), 64'(v42.hx));
    chk("blink_off_ready", 64'(ready), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
